mem_requester: RTL

Host-side initiator for the latch-based 8-bit word memory. It accepts read/write commands on a ready/valid request port and decodes the address into a one-hot word select. It drives the memory-side select, rw and write-data lines, waits for the memory's `valid` acknowledge, and returns read data and status on a ready/valid response port. It also enforces an inter-access gap and a watchdog timeout, so a stuck memory never hangs the host.

---
 rtl/mem_requester.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_requester.sv
// mem_requester: host-side initiator for the latch-based 8-bit word memory.
// Accepts one read/write command at a time, drives a one-hot word select to
// the memory, waits for its acknowledge (or a watchdog timeout), inserts a
// one-cycle hold gap and returns data/status on a ready/valid response port.
module mem_requester #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [7:0]             req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic [(1<<ADDR_W)-1:0] mem_sel,
    output logic                   mem_rw,
    output logic [7:0]             mem_wdata,
    input  logic [7:0]             mem_rdata_n,
    input  logic                   mem_valid
);

    localparam int         SEL_W     = 1 << ADDR_W;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        RESP
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       write_q;

    // Access sequencer; every output is a register so the latch enables
    // reaching the memory are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            write_q   <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
            mem_sel   <= '0;
            mem_rw    <= 1'b0;
            mem_wdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready comes up one edge after reset release
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        mem_sel   <= SEL_W'(1) << req_addr;
                        mem_rw    <= req_write;
                        mem_wdata <= req_wdata;
                        wait_cnt  <= 8'd1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // acknowledge takes priority over a coincident timeout
                    if (mem_valid) begin
                        mem_sel   <= '0;
                        mem_rw    <= 1'b0;
                        rsp_rdata <= write_q ? 8'h00 : ~mem_rdata_n;
                        rsp_err   <= 1'b0;
                        state     <= GAP;
                    end else if (wait_cnt == TIMEOUT_C) begin
                        mem_sel   <= '0;
                        mem_rw    <= 1'b0;
                        rsp_rdata <= 8'h00;
                        rsp_err   <= 1'b1;
                        state     <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                GAP: begin
                    // enable is already low; wdata is still held this cycle
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        mem_wdata <= 8'h00;
                        wait_cnt  <= 8'd0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
